// File: rtl/alu_result_checker.sv
//-----------------------------------------------------------------------------
// alu_result_checker
//
// Response-side checker for a 74381-style ALU. Every stimulus vector applied
// to the ALU is also presented here. The checker computes the golden F, Cout
// and overflow itself, delays that expectation by DUT_LAT cycles so it lines
// up with the ALU's response, and then compares. It keeps saturating pass and
// fail counters and freezes a snapshot of the first mismatch of a run.
//
// Run control is a four-state machine:
//   IDLE  -> waiting for start, vectors ignored
//   RUN   -> vectors accepted and compared
//   DRAIN -> no new vectors, waits DUT_LAT cycles for in-flight compares
//   DONE  -> results frozen until the next start
//
// Parameters:
//   WIDTH    operand/result width (at least 2)
//   DUT_LAT  cycles from stimulus to valid ALU outputs, 0..15 (0 = comb ALU)
//   CNT_W    pass/fail counter width (saturating)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      pulse: clear counters, capture and delay line, enter RUN
//   stop       pulse: end the run once in-flight compares have drained
//   in_valid   a stimulus vector is applied to the ALU this cycle
//   a, b       operands as applied to the ALU
//   s          function select as applied to the ALU
//   c_in       carry-in as applied to the ALU
//   dut_f      ALU result
//   dut_cout   ALU carry-out
//   dut_ovf    ALU overflow
//   busy       state is RUN or DRAIN
//   done       state is DONE
//   all_pass   in DONE: no failures and at least one pass; 0 elsewhere
//   pass_cnt   number of matching compares
//   fail_cnt   number of mismatching compares
//   err_valid  sticky flag, a mismatch has been captured
//   err_s      select of the first mismatch
//   err_f_exp  expected F of the first mismatch
//   err_f_got  ALU F of the first mismatch
//
// All outputs are registered.
//-----------------------------------------------------------------------------
module alu_result_checker #(
  parameter int WIDTH   = 32,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  input  logic             c_in,
  input  logic [WIDTH-1:0] dut_f,
  input  logic             dut_cout,
  input  logic             dut_ovf,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_valid,
  output logic [2:0]       err_s,
  output logic [WIDTH-1:0] err_f_exp,
  output logic [WIDTH-1:0] err_f_got
);

  // Run-control states (legacy-compatible encoding).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Expectation payload: {ovf, cout, f, s}.
  localparam int PW = WIDTH + 5;

  // DRAIN lasts exactly DUT_LAT cycles: the down-counter is loaded with
  // DUT_LAT-1 on entry and the exit is taken in the cycle it reads zero.
  localparam logic [3:0] DRAIN_LOAD = (DUT_LAT > 0) ? 4'(DUT_LAT - 1) : 4'd0;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  //---------------------------------------------------------------------------
  // Golden ALU model. Returns {ovf, cout, f}.
  // Arithmetic selects reduce to x + y + cin with x/y chosen per select, so
  // subtraction is handled by inverting one operand. Overflow is derived from
  // the carry into the MSB (a separate (WIDTH-1)-bit add) XOR the carry out.
  //---------------------------------------------------------------------------
  function automatic logic [WIDTH+1:0] golden_calc(
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [2:0]       sel,
    input logic             cin
  );
    logic [WIDTH-1:0] x_v;
    logic [WIDTH-1:0] y_v;
    logic [WIDTH-1:0] f_v;
    logic [WIDTH:0]   sum_v;
    logic [WIDTH-1:0] low_v;
    logic             arith_v;
    logic             cout_v;
    logic             ovf_v;

    x_v     = '0;
    y_v     = '0;
    f_v     = '0;
    arith_v = 1'b0;
    case (sel)
      3'd0: f_v = '0;
      3'd1: begin
        x_v     = op_b;
        y_v     = ~op_a;
        arith_v = 1'b1;
      end
      3'd2: begin
        x_v     = op_a;
        y_v     = ~op_b;
        arith_v = 1'b1;
      end
      3'd3: begin
        x_v     = op_a;
        y_v     = op_b;
        arith_v = 1'b1;
      end
      3'd4: f_v = op_a ^ op_b;
      3'd5: f_v = op_a | op_b;
      3'd6: f_v = op_a & op_b;
      3'd7: f_v = '1;
      default: f_v = '0;
    endcase

    sum_v = {1'b0, x_v} + {1'b0, y_v} + {{WIDTH{1'b0}}, cin};
    // Bit WIDTH-1 of this narrower sum is the carry into the MSB.
    low_v = {1'b0, x_v[WIDTH-2:0]} + {1'b0, y_v[WIDTH-2:0]}
          + {{(WIDTH-1){1'b0}}, cin};

    if (arith_v) begin
      f_v    = sum_v[WIDTH-1:0];
      cout_v = sum_v[WIDTH];
      ovf_v  = low_v[WIDTH-1] ^ sum_v[WIDTH];
    end else begin
      cout_v = 1'b0;
      ovf_v  = 1'b0;
    end

    return {ovf_v, cout_v, f_v};
  endfunction

  //---------------------------------------------------------------------------
  // Declarations
  //---------------------------------------------------------------------------
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [3:0]       drain_r;
  logic [3:0]       drain_nxt_s;

  logic             acc_s;
  logic [WIDTH+1:0] gold_s;
  logic [PW-1:0]    head_s;
  logic             tail_vld_s;
  logic [PW-1:0]    tail_data_s;

  logic [WIDTH-1:0] exp_f_s;
  logic             exp_cout_s;
  logic             exp_ovf_s;
  logic [2:0]       exp_sel_s;

  logic             cmp_en_s;
  logic             match_s;

  logic [CNT_W-1:0] pass_nxt_s;
  logic [CNT_W-1:0] fail_nxt_s;
  logic             err_valid_nxt_s;
  logic [2:0]       err_s_nxt_s;
  logic [WIDTH-1:0] err_f_exp_nxt_s;
  logic [WIDTH-1:0] err_f_got_nxt_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             all_pass_nxt_s;

  //---------------------------------------------------------------------------
  // Vector acceptance and expectation generation.
  // A start in the same cycle flushes everything, so that cycle's vector is
  // not taken into the new run.
  //---------------------------------------------------------------------------
  assign acc_s  = in_valid && (state_r == ST_RUN) && !start;
  assign gold_s = golden_calc(a, b, s, c_in);
  assign head_s = {gold_s, s};

  //---------------------------------------------------------------------------
  // Expectation delay line: DUT_LAT stages of valid + payload. With DUT_LAT=0
  // the expectation is compared in the cycle it is computed.
  //---------------------------------------------------------------------------
  generate
    if (DUT_LAT == 0) begin : g_no_delay
      assign tail_vld_s  = acc_s;
      assign tail_data_s = head_s;
    end else begin : g_delay
      logic [DUT_LAT-1:0] vld_r;
      logic [PW-1:0]      data_r [DUT_LAT];

      // Shift expectations toward the compare point; reset and start flush.
      always_ff @(posedge clk) begin
        if (rst || start) begin
          vld_r <= '0;
          for (int i = 0; i < DUT_LAT; i++) begin
            data_r[i] <= '0;
          end
        end else begin
          vld_r[0]  <= acc_s;
          data_r[0] <= head_s;
          for (int i = 1; i < DUT_LAT; i++) begin
            vld_r[i]  <= vld_r[i-1];
            data_r[i] <= data_r[i-1];
          end
        end
      end

      assign tail_vld_s  = vld_r[DUT_LAT-1];
      assign tail_data_s = data_r[DUT_LAT-1];
    end
  endgenerate

  assign exp_sel_s  = tail_data_s[2:0];
  assign exp_f_s    = tail_data_s[WIDTH+2:3];
  assign exp_cout_s = tail_data_s[WIDTH+3];
  assign exp_ovf_s  = tail_data_s[WIDTH+4];

  //---------------------------------------------------------------------------
  // Compare. Expectations leaving the delay line while IDLE or DONE are
  // dropped; a start in the compare cycle also drops them.
  //---------------------------------------------------------------------------
  assign cmp_en_s = tail_vld_s && !start &&
                    ((state_r == ST_RUN) || (state_r == ST_DRAIN));
  assign match_s  = (exp_f_s == dut_f) && (exp_cout_s == dut_cout) &&
                    (exp_ovf_s == dut_ovf);

  //---------------------------------------------------------------------------
  // Next-state logic for the run-control FSM and drain counter.
  //---------------------------------------------------------------------------
  always_comb begin
    state_nxt_s = state_r;
    drain_nxt_s = drain_r;
    if (start) begin
      state_nxt_s = ST_RUN;
      drain_nxt_s = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          if (stop) begin
            if (DUT_LAT > 0) begin
              state_nxt_s = ST_DRAIN;
              drain_nxt_s = DRAIN_LOAD;
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_r == 4'd0) begin
            state_nxt_s = ST_DONE;
          end else begin
            drain_nxt_s = drain_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          drain_nxt_s = 4'd0;
        end
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Next values for counters, first-mismatch capture and status flags.
  // Counters saturate at all-ones instead of wrapping.
  //---------------------------------------------------------------------------
  always_comb begin
    pass_nxt_s      = pass_cnt;
    fail_nxt_s      = fail_cnt;
    err_valid_nxt_s = err_valid;
    err_s_nxt_s     = err_s;
    err_f_exp_nxt_s = err_f_exp;
    err_f_got_nxt_s = err_f_got;
    if (start) begin
      pass_nxt_s      = '0;
      fail_nxt_s      = '0;
      err_valid_nxt_s = 1'b0;
      err_s_nxt_s     = 3'd0;
      err_f_exp_nxt_s = '0;
      err_f_got_nxt_s = '0;
    end else if (cmp_en_s) begin
      if (match_s) begin
        if (pass_cnt != '1) begin
          pass_nxt_s = pass_cnt + CNT_ONE;
        end else begin
          pass_nxt_s = pass_cnt;
        end
      end else begin
        if (fail_cnt != '1) begin
          fail_nxt_s = fail_cnt + CNT_ONE;
        end else begin
          fail_nxt_s = fail_cnt;
        end
        if (!err_valid) begin
          err_valid_nxt_s = 1'b1;
          err_s_nxt_s     = exp_sel_s;
          err_f_exp_nxt_s = exp_f_s;
          err_f_got_nxt_s = dut_f;
        end else begin
          err_valid_nxt_s = err_valid;
        end
      end
    end else begin
      pass_nxt_s = pass_cnt;
    end

    busy_nxt_s     = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
    done_nxt_s     = (state_nxt_s == ST_DONE);
    all_pass_nxt_s = done_nxt_s && (fail_nxt_s == '0) && (pass_nxt_s != '0);
  end

  // FSM state and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      drain_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      drain_r <= drain_nxt_s;
    end
  end

  // Counter, capture and status-flag output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_valid <= 1'b0;
      err_s     <= 3'd0;
      err_f_exp <= '0;
      err_f_got <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      all_pass  <= 1'b0;
    end else begin
      pass_cnt  <= pass_nxt_s;
      fail_cnt  <= fail_nxt_s;
      err_valid <= err_valid_nxt_s;
      err_s     <= err_s_nxt_s;
      err_f_exp <= err_f_exp_nxt_s;
      err_f_got <= err_f_got_nxt_s;
      busy      <= busy_nxt_s;
      done      <= done_nxt_s;
      all_pass  <= all_pass_nxt_s;
    end
  end

endmodule
